// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file operand sequencer.
// Holds default widths, the hard-wired zero register index and the FSM state encoding.
// Imported by regfile_sequencer and regfile_fwd_mux.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Index of the hard-wired zero register (x0).
    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_fwd_mux.sv
// Operand select for one source operand: forces x0 to zero and, when built with
// REGFILE_SEQ_FORWARD_EN, substitutes a same-cycle writeback hitting this index.
// Purely combinational, no backpressure.
// Ports: idx (latched source index), base (register-file or held operand),
//        wr_en/wr_idx/wr_data (accepted nonzero writeback, forwarding builds only),
//        result (value to load into the operand register).
module regfile_fwd_mux
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] base,
`ifdef REGFILE_SEQ_FORWARD_EN
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_idx,
    input  logic [DATA_W-1:0] wr_data,
`endif
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = base;
        if (idx == ADDR_W'(REG_ZERO)) begin
            result = '0;
        end
`ifdef REGFILE_SEQ_FORWARD_EN
        // wr_en is already qualified with a nonzero destination, so a hit can
        // never overwrite the x0 zeroing above.
        else if (wr_en && (wr_idx == idx)) begin
            result = wr_data;
        end
`endif
    end

endmodule

// File: rtl/regfile_sequencer.sv
// Sequences operand fetches and writebacks over one shared register-file port.
// Latency: request accepted in cycle N, op_valid from N+3; at most one request per 4 cycles.
// Backpressure: op_valid/op_a/op_b held until op_ready; writebacks stalled only in RD, win over requests in IDLE.
// Optional feature macro: REGFILE_SEQ_FORWARD_EN (writeback-to-operand forwarding in CAP/HOLD).
// Ports: clock/reset (async active-high); req_* request in; op_* operands out;
//        wb_* writeback in; rf_* shared register-file port (rf_a/rf_b registered read data).
module regfile_sequencer
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rs1,
    input  logic [ADDR_W-1:0] req_rs2,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              rf_enable,
    output logic              rf_read_write,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [ADDR_W-1:0] rf_rs1,
    output logic [ADDR_W-1:0] rf_rs2,
    output logic [DATA_W-1:0] rf_din,
    input  logic [DATA_W-1:0] rf_a,
    input  logic [DATA_W-1:0] rf_b
);

    state_t            state;
    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] din_q;

    logic              wb_acc;
    logic              wr_en;
    logic [DATA_W-1:0] base_a;
    logic [DATA_W-1:0] base_b;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    // Handshakes are gated by reset so nothing is accepted while it is held.
    assign wb_ready  = !reset && (state != RD);
    assign req_ready = !reset && (state == IDLE) && !wb_valid;
    assign wb_acc    = wb_valid && wb_ready;

    // A write to x0 is accepted but never reaches the port.
    assign wr_en = wb_acc && (wb_rd != ADDR_W'(REG_ZERO));

    assign rf_enable     = wr_en || (!reset && (state == RD));
    assign rf_read_write = wr_en;
    assign rf_rd         = wr_en ? wb_rd   : rd_q;
    assign rf_din        = wr_en ? wb_data : din_q;
    // The latched indices only change on request acceptance, so they already
    // hold their last values outside RD.
    assign rf_rs1        = rs1_q;
    assign rf_rs2        = rs2_q;

    // CAP loads fresh read data; HOLD recirculates the held operand so a
    // forwarded writeback can still replace it.
    assign base_a = (state == CAP) ? rf_a : op_a;
    assign base_b = (state == CAP) ? rf_b : op_b;

    regfile_fwd_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mux_a (
        .idx     (rs1_q),
        .base    (base_a),
`ifdef REGFILE_SEQ_FORWARD_EN
        .wr_en   (wr_en),
        .wr_idx  (wb_rd),
        .wr_data (wb_data),
`endif
        .result  (sel_a)
    );

    regfile_fwd_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mux_b (
        .idx     (rs2_q),
        .base    (base_b),
`ifdef REGFILE_SEQ_FORWARD_EN
        .wr_en   (wr_en),
        .wr_idx  (wb_rd),
        .wr_data (wb_data),
`endif
        .result  (sel_b)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            din_q    <= '0;
        end else begin
            if (wr_en) begin
                rd_q  <= wb_rd;
                din_q <= wb_data;
            end
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        rs1_q <= req_rs1;
                        rs2_q <= req_rs2;
                        state <= RD;
                    end
                end
                RD: begin
                    state <= CAP;
                end
                CAP: begin
                    op_a     <= sel_a;
                    op_b     <= sel_b;
                    op_valid <= 1'b1;
                    state    <= HOLD;
                end
                HOLD: begin
                    op_a <= sel_a;
                    op_b <= sel_b;
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural register file behind the port.
// Inputs change just after the falling edge and outputs are sampled 1 ns later.
// Index 0 of the register-file model returns a nonzero pattern so operand zeroing is visible.
module tb_regfile_sequencer;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_rs1;
    logic [AW-1:0] req_rs2;
    logic          op_valid;
    logic          op_ready;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          rf_enable;
    logic          rf_read_write;
    logic [AW-1:0] rf_rd;
    logic [AW-1:0] rf_rs1;
    logic [AW-1:0] rf_rs2;
    logic [DW-1:0] rf_din;
    logic [DW-1:0] rf_a;
    logic [DW-1:0] rf_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    regfile_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_rs1       (req_rs1),
        .req_rs2       (req_rs2),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_a          (op_a),
        .op_b          (op_b),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .rf_enable     (rf_enable),
        .rf_read_write (rf_read_write),
        .rf_rd         (rf_rd),
        .rf_rs1        (rf_rs1),
        .rf_rs2        (rf_rs2),
        .rf_din        (rf_din),
        .rf_a          (rf_a),
        .rf_b          (rf_b)
    );

    // Register-file model: synchronous write, registered read data.
    logic [DW-1:0] mem [32];
    always @(posedge clock) begin
        if (rf_enable && rf_read_write) mem[rf_rd] <= rf_din;
        if (rf_enable && !rf_read_write) begin
            rf_a <= (rf_rs1 == 0) ? 32'hBAD0_BAD0 : mem[rf_rs1];
            rf_b <= (rf_rs2 == 0) ? 32'hBAD0_BAD0 : mem[rf_rs2];
        end
    end

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; op_ready = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h6666_6666;
        repeat (2) @(negedge clock);
        #1;
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid got %h exp 0", op_valid); end
        checks++; if (op_a !== 32'h0) begin errors++; $display("FAIL reset_op_a got %h exp 0", op_a); end
        checks++; if (op_b !== 32'h0) begin errors++; $display("FAIL reset_op_b got %h exp 0", op_b); end
        checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL reset_wb_ready got %h exp 0", wb_ready); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %h exp 0", req_ready); end
        checks++; if (rf_enable !== 1'b0) begin errors++; $display("FAIL reset_rf_enable got %h exp 0", rf_enable); end
        checks++; if (rf_read_write !== 1'b0) begin errors++; $display("FAIL reset_rf_rw got %h exp 0", rf_read_write); end
        checks++; if (rf_rd !== 5'd0 || rf_rs1 !== 5'd0 || rf_din !== 32'h0) begin
            errors++; $display("FAIL reset_latched got rd=%h rs1=%h din=%h exp 0", rf_rd, rf_rs1, rf_din); end
        @(negedge clock);
        reset = 1'b0; wb_valid = 1'b0;
    endtask

    task automatic test_write_read;
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        #1;
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL wr_wb_ready got %h exp 1", wb_ready); end
        checks++; if (rf_enable !== 1'b1 || rf_read_write !== 1'b1) begin
            errors++; $display("FAIL wr_port got en=%h rw=%h exp 1 1", rf_enable, rf_read_write); end
        checks++; if (rf_rd !== 5'd5 || rf_din !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wr_addr_data got %h %h exp 05 deadbeef", rf_rd, rf_din); end
        @(negedge clock);
        wb_valid = 1'b0; req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_req_ready got %h exp 1", req_ready); end
        @(negedge clock);
        req_valid = 1'b0;
        #1;
        checks++; if (rf_enable !== 1'b1 || rf_read_write !== 1'b0 || rf_rs1 !== 5'd5 || rf_rs2 !== 5'd0) begin
            errors++; $display("FAIL rd_issue got en=%h rw=%h rs1=%h rs2=%h exp 1 0 05 00",
                               rf_enable, rf_read_write, rf_rs1, rf_rs2); end
        checks++; if (op_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++; $display("FAIL rd_flags got op_valid=%h req_ready=%h exp 0 0", op_valid, req_ready); end
        @(negedge clock);
        #1;
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL cap_op_valid got %h exp 0", op_valid); end
        @(negedge clock);
        #1;
        checks++; if (op_valid !== 1'b1 || op_a !== 32'hDEAD_BEEF || op_b !== 32'h0) begin
            errors++; $display("FAIL wr_operands got v=%h a=%h b=%h exp 1 deadbeef 0", op_valid, op_a, op_b); end
        checks++; if (rf_enable !== 1'b0) begin errors++; $display("FAIL hold_rf_enable got %h exp 0", rf_enable); end
        @(negedge clock);
        #1;
        checks++; if (op_valid !== 1'b1 || op_a !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL hold_stable got v=%h a=%h exp 1 deadbeef", op_valid, op_a); end
        op_ready = 1'b1;
        @(negedge clock);
        op_ready = 1'b0;
        #1;
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL release_op_valid got %h exp 0", op_valid); end
    endtask

    task automatic test_simultaneous;
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h77;
        req_valid = 1'b1; req_rs1 = 5'd7; req_rs2 = 5'd5;
        #1;
        checks++; if (wb_ready !== 1'b1 || req_ready !== 1'b0) begin
            errors++; $display("FAIL simul_prio got wb_ready=%h req_ready=%h exp 1 0", wb_ready, req_ready); end
        @(negedge clock);
        wb_valid = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL simul_accept got %h exp 1", req_ready); end
        @(negedge clock);
        req_valid = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        checks++; if (op_valid !== 1'b1 || op_a !== 32'h77 || op_b !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL simul_operands got v=%h a=%h b=%h exp 1 77 deadbeef", op_valid, op_a, op_b); end
        op_ready = 1'b1;
        @(negedge clock);
        op_ready = 1'b0;
    endtask

    task automatic test_wb_blocked_rd;
        req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd7;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL blk_req_ready got %h exp 1", req_ready); end
        @(negedge clock);
        req_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h99;
        #1;
        checks++; if (wb_ready !== 1'b0 || rf_read_write !== 1'b0) begin
            errors++; $display("FAIL blk_rd got wb_ready=%h rw=%h exp 0 0", wb_ready, rf_read_write); end
        checks++; if (rf_rd !== 5'd7 || rf_din !== 32'h77) begin
            errors++; $display("FAIL blk_hold_last got rd=%h din=%h exp 07 77", rf_rd, rf_din); end
        @(negedge clock);
        #1;
        checks++; if (wb_ready !== 1'b1 || rf_enable !== 1'b1 || rf_read_write !== 1'b1 || rf_rd !== 5'd9 || rf_din !== 32'h99) begin
            errors++; $display("FAIL blk_cap_accept got rdy=%h en=%h rw=%h rd=%h din=%h exp 1 1 1 09 99",
                               wb_ready, rf_enable, rf_read_write, rf_rd, rf_din); end
        @(negedge clock);
        wb_valid = 1'b0;
        #1;
        checks++; if (op_valid !== 1'b1 || op_a !== 32'hDEAD_BEEF || op_b !== 32'h77) begin
            errors++; $display("FAIL blk_operands got v=%h a=%h b=%h exp 1 deadbeef 77", op_valid, op_a, op_b); end
        op_ready = 1'b1;
        @(negedge clock);
        op_ready = 1'b0;
    endtask

    task automatic test_forward;
        logic [DW-1:0] exp_a;
`ifdef REGFILE_SEQ_FORWARD_EN
        exp_a = 32'h22;
`else
        exp_a = 32'h11;
`endif
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h11;
        @(negedge clock);
        wb_valid = 1'b0; req_valid = 1'b1; req_rs1 = 5'd3; req_rs2 = 5'd9;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        checks++; if (op_valid !== 1'b1 || op_a !== 32'h11 || op_b !== 32'h99) begin
            errors++; $display("FAIL fwd_before got v=%h a=%h b=%h exp 1 11 99", op_valid, op_a, op_b); end
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h22;
        #1;
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL fwd_hold_wb_ready got %h exp 1", wb_ready); end
        @(negedge clock);
        wb_valid = 1'b0;
        #1;
        checks++; if (op_valid !== 1'b1 || op_a !== exp_a || op_b !== 32'h99) begin
            errors++; $display("FAIL fwd_after got v=%h a=%h b=%h exp 1 %h 99", op_valid, op_a, op_b, exp_a); end
        op_ready = 1'b1;
        @(negedge clock);
        op_ready = 1'b0;
    endtask

    task automatic test_x0_write;
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        #1;
        checks++; if (wb_ready !== 1'b1 || rf_enable !== 1'b0) begin
            errors++; $display("FAIL x0_write got wb_ready=%h en=%h exp 1 0", wb_ready, rf_enable); end
        checks++; if (rf_rd !== 5'd3 || rf_din !== 32'h22) begin
            errors++; $display("FAIL x0_hold_last got rd=%h din=%h exp 03 22", rf_rd, rf_din); end
        @(negedge clock);
        wb_valid = 1'b0; req_valid = 1'b1; req_rs1 = 5'd0; req_rs2 = 5'd0;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        checks++; if (op_valid !== 1'b1 || op_a !== 32'h0 || op_b !== 32'h0) begin
            errors++; $display("FAIL x0_read got v=%h a=%h b=%h exp 1 0 0", op_valid, op_a, op_b); end
        op_ready = 1'b1;
        @(negedge clock);
        op_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd7; op_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++; if (req_ready !== (c % 4 == 0) || op_valid !== (c % 4 == 3)) begin
                errors++; $display("FAIL b2b_cycle%0d got req_ready=%h op_valid=%h exp %0d %0d",
                                   c, req_ready, op_valid, (c % 4 == 0), (c % 4 == 3)); end
            if (c % 4 == 3) begin
                checks++; if (op_a !== 32'hDEAD_BEEF || op_b !== 32'h77) begin
                    errors++; $display("FAIL b2b_operands%0d got a=%h b=%h exp deadbeef 77", c, op_a, op_b); end
            end
            if (c == 7) req_valid = 1'b0;
            @(negedge clock);
        end
        op_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h1234;
        @(negedge clock);
        wb_valid = 1'b0; req_valid = 1'b1; req_rs1 = 5'd4; req_rs2 = 5'd5;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        checks++; if (op_valid !== 1'b1 || op_a !== 32'h1234) begin
            errors++; $display("FAIL mid_before got v=%h a=%h exp 1 1234", op_valid, op_a); end
        reset = 1'b1; wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h6;
        #1;
        checks++; if (op_valid !== 1'b0 || op_a !== 32'h0 || op_b !== 32'h0) begin
            errors++; $display("FAIL mid_async_clear got v=%h a=%h b=%h exp 0 0 0", op_valid, op_a, op_b); end
        checks++; if (wb_ready !== 1'b0 || rf_enable !== 1'b0) begin
            errors++; $display("FAIL mid_gated got wb_ready=%h en=%h exp 0 0", wb_ready, rf_enable); end
        @(negedge clock);
        reset = 1'b0; wb_valid = 1'b0; req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd4;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_idle_after got %h exp 1", req_ready); end
        @(negedge clock);
        req_valid = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        checks++; if (op_valid !== 1'b1 || op_a !== 32'hDEAD_BEEF || op_b !== 32'h1234) begin
            errors++; $display("FAIL mid_recover got v=%h a=%h b=%h exp 1 deadbeef 1234", op_valid, op_a, op_b); end
        op_ready = 1'b1;
        @(negedge clock);
        op_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_simultaneous();
        test_wb_blocked_rd();
        test_forward();
        test_x0_write();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sequencer.md
REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
- REQ-001: Parameters SHALL be:
  - DATA_W, default 32, operand/data width.
  - ADDR_W, default 5, register index width (32 registers).
- REQ-002: Ports SHALL be (name, direction, width, meaning):
  - clock, in, 1, rising-edge clock.
  - reset, in, 1, asynchronous active-high reset.
  - req_valid, in, 1, operand-fetch request.
  - req_ready, out, 1, request accepted.
  - req_rs1, in, ADDR_W, source index 1.
  - req_rs2, in, ADDR_W, source index 2.
  - op_valid, out, 1, operands available.
  - op_ready, in, 1, consumer takes operands.
  - op_a, out, DATA_W, operand 1.
  - op_b, out, DATA_W, operand 2.
  - wb_valid, in, 1, writeback request.
  - wb_ready, out, 1, writeback accepted.
  - wb_rd, in, ADDR_W, destination index.
  - wb_data, in, DATA_W, writeback data.
  - rf_enable, out, 1, register-file port enable.
  - rf_read_write, out, 1, 1 = write, 0 = read.
  - rf_rd, out, ADDR_W, write index.
  - rf_rs1, out, ADDR_W, read index 1.
  - rf_rs2, out, ADDR_W, read index 2.
  - rf_din, out, DATA_W, write data.
  - rf_a, in, DATA_W, registered read data 1.
  - rf_b, in, DATA_W, registered read data 2.
- REQ-003: Clock and reset SHALL be fixed as: reset reset, asynchronous, active-high; clock clock.

Function
- REQ-004: The block SHALL drive a single shared register-file port. rf_a and rf_b are valid in the cycle after a read is issued (rf_enable=1, rf_read_write=0).
- REQ-005: The FSM SHALL have states IDLE, RD, CAP and HOLD.
- REQ-006: IDLE behaviour:
  - If wb_valid=1: wb_ready=1 and req_ready=0 in the same cycle (writeback has priority).
  - Else if req_valid=1: req_ready=1, latch rs1/rs2, go to RD.
- REQ-007: RD SHALL drive rf_enable=1, rf_read_write=0 and rf_rs1/rf_rs2 from the latched indices, with wb_ready=0, then go to CAP.
- REQ-008: CAP SHALL capture rf_a/rf_b into the op_a/op_b registers and go to HOLD. op_valid SHALL assert on the next cycle.
- REQ-009: HOLD SHALL keep op_valid=1 with op_a/op_b stable until op_ready=1, then go to IDLE. op_valid SHALL deassert the following cycle.
- REQ-010: Latency SHALL be fixed: request accepted in cycle N, op_valid=1 from cycle N+3. Throughput is at most one request per 4 cycles with op_ready held at 1.
- REQ-011: Writebacks SHALL be accepted (wb_ready=1) in IDLE, CAP and HOLD, and SHALL never be accepted in RD.
- REQ-012: An accepted writeback SHALL drive, combinationally in the same cycle: rf_enable=1, rf_read_write=1, rf_rd=wb_rd, rf_din=wb_data.
- REQ-013: Register x0:
  - A write with wb_rd=0 SHALL be accepted (wb_ready=1) but SHALL drive rf_enable=0.
  - A read of index 0 SHALL yield operand 0 regardless of rf_a/rf_b.
- REQ-014: When no port access is required, rf_enable SHALL be 0. rf_rd, rf_rs1, rf_rs2 and rf_din SHALL then hold their last values.
- REQ-015: req_ready SHALL be 0 in every state except IDLE.

Reset
- REQ-016: While reset=1:
  - state=IDLE.
  - op_valid=0, op_a=0, op_b=0.
  - req_ready=0, wb_ready=0, rf_enable=0, rf_read_write=0.
  - All latched indices and data = 0.
- REQ-017: Reset mid-transaction SHALL discard the in-flight request without retry. op_valid SHALL fall asynchronously.
- REQ-018: After reset release, the first edge SHALL observe state IDLE.

Configuration
- REQ-019: Macro REGFILE_SEQ_FORWARD_EN SHALL control write forwarding.
  - Defined: a writeback accepted in CAP or HOLD whose wb_rd is nonzero and equals a latched rs1/rs2 SHALL replace the matching operand (both operands if both match), visible from the next cycle. In CAP, the writeback value SHALL override rf_a/rf_b.
  - Undefined: operands SHALL reflect the register-file read only, and no comparison logic SHALL exist.

Structure
- REQ-020: Package regfile_pkg SHALL hold:
  - DATA_W and ADDR_W defaults.
  - Constant REG_ZERO=0.
  - The FSM state enum (IDLE, RD, CAP, HOLD).
- REQ-021: Operand selection (x0 zeroing plus optional forwarding) SHALL be a sub-module regfile_fwd_mux, instanced twice. Its forwarding path SHALL be compiled only under REGFILE_SEQ_FORWARD_EN.

Verification
- REQ-022: Write then read:
  - Stimulus: wb x5=0xDEADBEEF in IDLE; then req rs1=5, rs2=0.
  - Response: rf_read_write=1 on the write cycle; op_a=0xDEADBEEF and op_b=0 with op_valid at acceptance+3.
- REQ-023: Simultaneous requests:
  - Stimulus: req_valid and wb_valid both high in IDLE.
  - Response: wb_ready=1, req_ready=0; the request is accepted the next cycle.
- REQ-024: Writeback blocked in RD:
  - Stimulus: wb_valid held from RD.
  - Response: wb_ready=0 in RD; the writeback is accepted in CAP.
- REQ-025: Forwarding, with macro defined:
  - Stimulus: x3=0x11 in the register file; req rs1=3; wb x3=0x22 accepted in HOLD.
  - Response: op_a changes 0x11 -> 0x22 the next cycle.
  - Without the macro, op_a stays 0x11.
- REQ-026: Write to x0:
  - Stimulus: wb x0=0xFFFFFFFF.
  - Response: wb_ready=1 and rf_enable=0; a subsequent read of x0 returns 0.
- REQ-027: Reset during operation:
  - Stimulus: reset asserted in HOLD with op_a=0x1234 and op_ready=0.
  - Response: op_valid=0 and op_a=0 immediately; state is IDLE after release.
